// File: rtl/fbw_arb_pkg.sv
// Shared types and constants for the frame-buffer write-port arbiter.
package fbw_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT_DEF = 4096;
endpackage

// File: rtl/fbw_arb_pick.sv
// Combinational winner select: one-hot winner plus index from a request vector.
// FBW_ARB_FIXED_PRIO_EN: lowest index wins; otherwise round-robin from ptr+1.
module fbw_arb_pick
  import fbw_arb_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] win,
  output logic [IDX_W-1:0] win_idx,
  output logic             vld
);
`ifdef FBW_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win     = '0;
    win_idx = '0;
    vld     = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!vld && req[i]) begin
        win[i]  = 1'b1;
        win_idx = IDX_W'(i);
        vld     = 1'b1;
      end
    end
  end
`else
  int idx;

  // Search order starts just after the last owner so it goes to the back of the line.
  always_comb begin
    win     = '0;
    win_idx = '0;
    vld     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(ptr) + k) % N_SRC;
      if (!vld && req[idx]) begin
        win[idx] = 1'b1;
        win_idx  = IDX_W'(idx);
        vld      = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/fbw_arb.sv
// Frame-granular arbiter for one frame-buffer write port; owner held until frame swap, abort or watchdog.
// Arbitration policy selected by FBW_ARB_FIXED_PRIO_EN (see fbw_arb_pick).
module fbw_arb
  import fbw_arb_pkg::*;
#(
  parameter int N_ROWS     = 64,
  parameter int N_COLS     = 64,
  parameter int N_SRC      = 2,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_SRC-1:0]              src_req,
  output logic [N_SRC-1:0]              src_gnt,
  input  logic [N_SRC*LOG_N_ROWS-1:0]   src_row_addr,
  input  logic [N_SRC-1:0]              src_row_store,
  input  logic [N_SRC-1:0]              src_row_swap,
  input  logic [N_SRC-1:0]              src_wren,
  input  logic [N_SRC-1:0]              src_frame_swap,
  input  logic [N_SRC*24-1:0]           src_data,
  input  logic [N_SRC*LOG_N_COLS-1:0]   src_col_addr,
  output logic [N_SRC-1:0]              src_row_rdy,
  output logic [N_SRC-1:0]              src_frame_rdy,
  output logic [LOG_N_ROWS-1:0]         fbw_row_addr,
  output logic                          fbw_row_store,
  output logic                          fbw_row_swap,
  output logic                          fbw_wren,
  output logic                          frame_swap,
  output logic [23:0]                   fbw_data,
  output logic [LOG_N_COLS-1:0]         fbw_col_addr,
  input  logic                          fbw_row_rdy,
  input  logic                          frame_rdy,
  output logic                          timeout
);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [N_SRC-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  logic [N_SRC-1:0]      pick_win;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;

  logic own, own_wren, own_store, own_swap, own_fswap, own_strb, rel_norm, wd_exp;

  fbw_arb_pick #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_pick (
    .req     (src_req),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .vld     (pick_vld)
  );

  assign own       = (state_q == ST_OWN);
  assign own_wren  = own & src_wren[owner_q];
  assign own_store = own & src_row_store[owner_q];
  assign own_swap  = own & src_row_swap[owner_q];
  assign own_fswap = own & src_frame_swap[owner_q];
  assign own_strb  = own_wren | own_store | own_swap | own_fswap;
  assign rel_norm  = own_fswap | (own & ~src_req[owner_q]);
  // Expiry only on an idle cycle, so it can never coincide with an owner frame swap.
  assign wd_exp    = (TIMEOUT != 0) && own && !own_strb && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_OWN;
          gnt_d   = pick_win;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        cnt_d = own_strb ? '0 : cnt_q + 1'b1;
        if (rel_norm || wd_exp) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          ptr_d     = owner_q;
          timeout_d = wd_exp && !rel_norm;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= IDX_W'(N_SRC - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign src_gnt       = gnt_q;
  assign timeout       = timeout_q;
  assign src_row_rdy   = own ? (gnt_q & {N_SRC{fbw_row_rdy}}) : '0;
  assign src_frame_rdy = own ? (gnt_q & {N_SRC{frame_rdy}})   : '0;

  assign fbw_row_addr  = own ? src_row_addr[owner_q*LOG_N_ROWS +: LOG_N_ROWS] : '0;
  assign fbw_col_addr  = own ? src_col_addr[owner_q*LOG_N_COLS +: LOG_N_COLS] : '0;
  assign fbw_data      = own ? src_data[owner_q*24 +: 24] : '0;
  assign fbw_wren      = own_wren;
  assign fbw_row_store = own_store;
  assign fbw_row_swap  = own_swap;
  assign frame_swap    = own_fswap;
endmodule

// File: tb/tb_fbw_arb.sv
// Directed bench for fbw_arb: reset, frame hand-over, non-owner isolation, watchdog, abort, async reset.
module tb_fbw_arb;
  localparam int NS = 2;
  localparam int LR = 6;
  localparam int LC = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   src_req, src_gnt, src_row_store, src_row_swap, src_wren, src_frame_swap;
  logic [NS-1:0]   src_row_rdy, src_frame_rdy;
  logic [NS*LR-1:0] src_row_addr;
  logic [NS*24-1:0] src_data;
  logic [NS*LC-1:0] src_col_addr;
  logic [LR-1:0]   fbw_row_addr;
  logic [LC-1:0]   fbw_col_addr;
  logic [23:0]     fbw_data;
  logic            fbw_row_store, fbw_row_swap, fbw_wren, frame_swap;
  logic            fbw_row_rdy, frame_rdy, timeout;

  int total = 0;
  int bad   = 0;
  logic [NS-1:0] exp_gnt2;

  always #5 clk = ~clk;

  fbw_arb #(.N_ROWS(64), .N_COLS(64), .N_SRC(NS), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_req(src_req), .src_gnt(src_gnt),
    .src_row_addr(src_row_addr), .src_row_store(src_row_store), .src_row_swap(src_row_swap),
    .src_wren(src_wren), .src_frame_swap(src_frame_swap), .src_data(src_data),
    .src_col_addr(src_col_addr), .src_row_rdy(src_row_rdy), .src_frame_rdy(src_frame_rdy),
    .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store), .fbw_row_swap(fbw_row_swap),
    .fbw_wren(fbw_wren), .frame_swap(frame_swap), .fbw_data(fbw_data),
    .fbw_col_addr(fbw_col_addr), .fbw_row_rdy(fbw_row_rdy), .frame_rdy(frame_rdy),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes;
    src_wren = '0; src_row_store = '0; src_row_swap = '0; src_frame_swap = '0;
  endtask

  initial begin
`ifdef FBW_ARB_FIXED_PRIO_EN
    exp_gnt2 = 2'b01;
`else
    exp_gnt2 = 2'b10;
`endif
    rst_n = 1'b0;
    src_req = 2'b11;
    clr_strobes();
    src_wren = 2'b11;
    src_row_addr = '0; src_data = '0; src_col_addr = '0;
    fbw_row_rdy = 1'b1; frame_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_gnt",   src_gnt, 2'b00);
    chk("rst_bus",   {fbw_wren, frame_swap, fbw_row_store, fbw_row_swap, fbw_data, fbw_col_addr, fbw_row_addr}, '0);
    chk("rst_rdy",   {src_row_rdy, src_frame_rdy, timeout}, '0);

    src_wren = '0;
    fbw_row_rdy = 1'b0; frame_rdy = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1 chk("pre_gnt", src_gnt, 2'b00);
    tick();
    chk("first_gnt", src_gnt, 2'b01);

    // Source 0 writes a row while source 1 sprays wren/frame_swap it does not own.
    src_row_addr[0 +: LR]  = 6'd5;
    src_row_addr[LR +: LR] = 6'd9;
    for (int c = 0; c < 64; c++) begin
      src_wren = 2'b11;
      src_frame_swap = {c[0], 1'b0};
      src_col_addr[0 +: LC]  = LC'(c);
      src_col_addr[LC +: LC] = LC'(63 - c);
      src_data[0 +: 24]  = 24'hA00000 + 24'(c);
      src_data[24 +: 24] = 24'h5F5F5F;
      fbw_row_rdy = c[0];
      frame_rdy   = c[1];
      #1;
      chk("col_bus", {fbw_wren, frame_swap, fbw_row_addr, fbw_col_addr, fbw_data},
          {1'b1, 1'b0, 6'd5, 6'(c), 24'hA00000 + 24'(c)});
      chk("col_rdy", {src_row_rdy, src_frame_rdy}, {1'b0, c[0], 1'b0, c[1]});
      tick();
    end
    clr_strobes();
    src_row_store = 2'b01;
    fbw_row_rdy = 1'b1;
    #1 chk("row_store", {fbw_row_store, fbw_wren, src_row_rdy}, {1'b1, 1'b0, 2'b01});
    tick();
    clr_strobes();
    src_frame_swap = 2'b01;
    frame_rdy = 1'b1;
    #1 chk("fswap", {frame_swap, src_frame_rdy}, {1'b1, 2'b01});
    tick();
    clr_strobes();
    chk("rel_gnt", src_gnt, 2'b00);
    chk("rel_bus", {frame_swap, fbw_wren, fbw_data, src_row_rdy, src_frame_rdy, timeout}, '0);
    tick();
    chk("gap_gnt", src_gnt, 2'b00);
    tick();
    chk("rr_gnt", src_gnt, exp_gnt2);

    // Owner idle: watchdog of 16 idle cycles.
    repeat (15) tick();
    chk("wd_hold", {src_gnt, timeout}, {exp_gnt2, 1'b0});
    tick();
    chk("wd_rel", {src_gnt, timeout}, {2'b00, 1'b1});
    tick();
    chk("wd_once", {src_gnt, timeout}, {2'b00, 1'b0});
    tick();
    chk("wd_regnt", src_gnt, 2'b01);

    // Source 0 aborts mid-row; its last write still goes through.
    src_req = 2'b10;
    src_wren = 2'b01;
    src_col_addr[0 +: LC] = 6'd17;
    src_data[0 +: 24] = 24'h123456;
    #1 chk("abort_pass", {fbw_wren, fbw_col_addr, fbw_data}, {1'b1, 6'd17, 24'h123456});
    tick();
    clr_strobes();
    chk("abort_rel", {src_gnt, frame_swap, timeout}, {2'b00, 1'b0, 1'b0});
    tick();
    tick();
    chk("abort_next", src_gnt, 2'b10);

    // Asynchronous reset in the middle of source 1's frame.
    src_wren = 2'b10;
    fbw_row_rdy = 1'b1;
    #1 chk("pre_arst", {fbw_wren, src_row_rdy}, {1'b1, 2'b10});
    #2 rst_n = 1'b0;
    #1 chk("arst_out", {src_gnt, fbw_wren, frame_swap, src_row_rdy, src_frame_rdy, fbw_data, timeout}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
